// File: rtl/subpel_row_sched.sv
// subpel_row_sched: row scheduler for the 8-tap HEVC luma sub-pel filters.
// Builds a sliding 8-pixel window from the input stream and presents it to
// FIR_A/B/C in parallel. It tags each full window, then captures the result
// selected by frac when the tag leaves the filter-latency pipeline. Results are
// buffered in an output FIFO. A credit check on FIFO space stops new pixels
// while the FIFO plus in-flight tags would exceed the FIFO depth.
// Optional feature: define SUBPEL_FULLPEL_EN to accept frac=0 (full-pel copy
// of window byte 3, delayed to line up with the filter results).
module subpel_row_sched #(
  parameter int ROW_W     = 16,
  parameter int FILT_LAT  = 1,
  parameter int OFIFO_DEP = 4
) (
  input  logic        clock,
  input  logic        reset_L,
  input  logic        start,
  input  logic [1:0]  frac,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [63:0] filt_win,
  input  logic [7:0]  res_a,
  input  logic [7:0]  res_b,
  input  logic [7:0]  res_c,
  output logic [7:0]  out_pix,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);

  localparam int PC_W  = $clog2(ROW_W + 8);
  localparam int PTR_W = $clog2(OFIFO_DEP);
  localparam int CNT_W = $clog2(OFIFO_DEP + 1);
  // Stage 0 marks "window presented"; FILT_LAT more stages cover the filter latency.
  localparam int STG   = FILT_LAT + 1;
  localparam int INF_W = $clog2(STG + 1);
  localparam logic [PC_W-1:0]  PIX_LAST     = PC_W'(ROW_W + 7);
  localparam logic [PC_W-1:0]  PIX_PRE_LAST = PC_W'(ROW_W + 6);
  localparam logic [PC_W-1:0]  PIX_PRE_TAG  = PC_W'(7);
  localparam logic [PTR_W-1:0] PTR_MAX      = PTR_W'(OFIFO_DEP - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        frac_reg;
  logic [PC_W-1:0]   pix_cnt_reg;
  logic [63:0]       win_reg, win_next;
  logic [STG-1:0]    tag_reg, last_reg;
  logic [INF_W-1:0]  inflight;
  logic [CNT_W-1:0]  fifo_cnt_reg;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [7:0]        fifo_data_reg [OFIFO_DEP];
  logic              fifo_last_reg [OFIFO_DEP];
  logic              err_reg;
  logic              frac_ok, start_ok, start_bad;
  logic              accept, issue, issue_last, push, pop;
  logic [7:0]        push_data;
  logic [31:0]       credit_sum;

`ifdef SUBPEL_FULLPEL_EN
  assign frac_ok = 1'b1;
`else
  assign frac_ok = (frac != 2'd0);
`endif

  assign start_ok   = (state_reg == ST_IDLE) && start && frac_ok;
  assign start_bad  = (state_reg == ST_IDLE) && start && !frac_ok;
  assign accept     = pix_valid && pix_ready;
  // Pixels 8..ROW_W+7 each complete a window worth filtering.
  assign issue      = accept && (pix_cnt_reg >= PIX_PRE_TAG);
  assign issue_last = accept && (pix_cnt_reg == PIX_PRE_LAST);
  assign win_next   = accept ? {pix_in, win_reg[63:8]} : win_reg;
  assign credit_sum = 32'(fifo_cnt_reg) + 32'(inflight);
  assign push       = tag_reg[STG-1];
  assign pop        = out_valid && out_ready;

  // Count tags still travelling through the filters
  always_comb begin
    inflight = '0;
    for (int i = 0; i < STG; i++) begin
      inflight = inflight + INF_W'(tag_reg[i]);
    end
  end

  // Next-state and status outputs
  always_comb begin
    state_next = state_reg;
    busy       = (state_reg != ST_IDLE);
    done       = (state_reg == ST_DONE);
    pix_ready  = (state_reg == ST_RUN) && (credit_sum < 32'(OFIFO_DEP));
    case (state_reg)
      ST_IDLE:  if (start_ok) state_next = ST_RUN;
      ST_RUN:   if (accept && (pix_cnt_reg == PIX_PRE_LAST)) state_next = ST_DRAIN;
      ST_DRAIN: if ((inflight == '0) && (fifo_cnt_reg == '0)) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register, latched fractional position and error pulse
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_reg <= ST_IDLE;
      frac_reg  <= 2'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= start_bad;
      if (start_ok) frac_reg <= frac;
    end
  end

  // Pixel counter: cleared in IDLE, saturates at the last pixel of the row
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      pix_cnt_reg <= '0;
    end else if (state_reg == ST_IDLE) begin
      pix_cnt_reg <= '0;
    end else if (accept && (pix_cnt_reg != PIX_LAST)) begin
      pix_cnt_reg <= pix_cnt_reg + PC_W'(1);
    end
  end

  // Sliding window: newest pixel enters byte 7, holds when nothing is accepted
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      win_reg <= '0;
    end else begin
      win_reg <= win_next;
    end
  end

  // Tag and last-flag pipelines matching the filter latency
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      tag_reg  <= '0;
      last_reg <= '0;
    end else begin
      tag_reg  <= {tag_reg[STG-2:0], issue};
      last_reg <= {last_reg[STG-2:0], issue_last};
    end
  end

`ifdef SUBPEL_FULLPEL_EN
  genvar gi;
  // Full-pel delay line: byte 3 of each new window travels with its tag
  for (gi = 0; gi < STG; gi++) begin : g_fp
    logic [7:0] data_reg;
    if (gi == 0) begin : g_head
      // First stage captures byte 3 of the window being formed
      always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) data_reg <= '0;
        else          data_reg <= win_next[31:24];
      end
    end else begin : g_tail
      // Later stages shift the captured byte along
      always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) data_reg <= '0;
        else          data_reg <= g_fp[gi-1].data_reg;
      end
    end
  end
`endif

  // Result select by latched fractional position
  always_comb begin
    push_data = 8'd0;
    case (frac_reg)
      2'd1:    push_data = res_a;
      2'd2:    push_data = res_b;
      2'd3:    push_data = res_c;
      default: begin
`ifdef SUBPEL_FULLPEL_EN
        push_data = g_fp[STG-1].data_reg;
`else
        push_data = 8'd0;
`endif
      end
    endcase
  end

  // Output FIFO: credit rule guarantees a push never finds it full without a pop
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
      for (int i = 0; i < OFIFO_DEP; i++) begin
        fifo_data_reg[i] <= 8'd0;
        fifo_last_reg[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_data_reg[wr_ptr_reg] <= push_data;
        fifo_last_reg[wr_ptr_reg] <= last_reg[STG-1];
        wr_ptr_reg <= (wr_ptr_reg == PTR_MAX) ? '0 : wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PTR_MAX) ? '0 : rd_ptr_reg + PTR_W'(1);
      end
      if (push && !pop) begin
        fifo_cnt_reg <= fifo_cnt_reg + CNT_W'(1);
      end else if (!push && pop) begin
        fifo_cnt_reg <= fifo_cnt_reg - CNT_W'(1);
      end
    end
  end

  assign err       = err_reg;
  assign filt_win  = win_reg;
  assign out_valid = (fifo_cnt_reg != '0);
  assign out_pix   = fifo_data_reg[rd_ptr_reg];
  assign out_last  = out_valid && fifo_last_reg[rd_ptr_reg];

endmodule

// File: tb/tb_subpel_row_sched.sv
// tb_subpel_row_sched: directed bench for subpel_row_sched with behavioural
// one-cycle FIR_A/B/C models. Expected samples are computed from the pixel row.
`timescale 1ns/1ps
module tb_subpel_row_sched;
  localparam int ROW_W = 16;
  localparam int NPIX  = ROW_W + 7;

  logic        clock = 1'b0;
  logic        reset_L;
  logic        start;
  logic [1:0]  frac;
  logic        busy, done, err;
  logic [7:0]  pix_in;
  logic        pix_valid, pix_ready;
  logic [63:0] filt_win;
  logic [7:0]  res_a = '0, res_b = '0, res_c = '0;
  logic [7:0]  out_pix;
  logic        out_valid, out_ready, out_last;

  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt = 0;
  int          fed_cnt  = 0;
  int          d0;
  logic        rnd_ready = 1'b0;
  logic [63:0] first_win;
  logic [7:0]  row_pix [NPIX];
  logic [7:0]  got_pix [$];
  logic        got_last [$];

  always #5 clock = ~clock;

  subpel_row_sched #(.ROW_W(16), .FILT_LAT(1), .OFIFO_DEP(4)) dut (
    .clock(clock), .reset_L(reset_L), .start(start), .frac(frac),
    .busy(busy), .done(done), .err(err),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .filt_win(filt_win), .res_a(res_a), .res_b(res_b), .res_c(res_c),
    .out_pix(out_pix), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  // HEVC luma 8-tap filter on a window (byte 0 oldest); fr=0 gives byte 3
  function automatic logic [7:0] fir8(input logic [63:0] w, input int fr);
    int c [8];
    int s;
    case (fr)
      1:       c = '{-1, 4, -10, 58, 17, -5, 1, 0};
      2:       c = '{-1, 4, -11, 40, 40, -11, 4, -1};
      3:       c = '{0, 1, -5, 17, 58, -10, 4, -1};
      default: c = '{0, 0, 0, 64, 0, 0, 0, 0};
    endcase
    s = 32;
    for (int k = 0; k < 8; k++) s += c[k] * int'(w[8*k +: 8]);
    s = s >>> 6;
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return 8'(s);
  endfunction

  // Expected sample j of the current row: filter over pixels j..j+7
  function automatic logic [7:0] model(input int fr, input int j);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = row_pix[j+k];
    return fir8(w, fr);
  endfunction

  // Filters: one cycle from window presented to result
  always @(posedge clock) begin
    res_a <= fir8(filt_win, 1);
    res_b <= fir8(filt_win, 2);
    res_c <= fir8(filt_win, 3);
  end

  // Output monitor: one line per delivered sample
  always @(negedge clock) begin
    if (out_valid && out_ready) begin
      got_pix.push_back(out_pix);
      got_last.push_back(out_last);
      $display("[%0t] out sample %0d pix=%0d last=%0b", $time, got_pix.size(), out_pix, out_last);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  // Random output backpressure when enabled
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_row(input logic [1:0] f);
    start = 1'b1;
    frac  = f;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic feed_row(input bit gap, input int npix);
    int cyc = 0;
    bit win_got = 1'b0;
    fed_cnt = 0;
    while (fed_cnt < npix && cyc < 600) begin
      pix_in    = row_pix[fed_cnt];
      pix_valid = !gap || (cyc % 2 == 0);
      @(negedge clock);
      if (pix_valid && pix_ready) fed_cnt++;
      @(posedge clock);
      #1;
      if (fed_cnt == 8 && !win_got) begin
        first_win = filt_win;
        win_got   = 1'b1;
      end
      cyc++;
    end
    pix_valid = 1'b0;
    check("feed_count", fed_cnt, npix);
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    bit seen = 1'b0;
    while (!seen && cyc < 400) begin
      @(negedge clock);
      if (done) seen = 1'b1;
      cyc++;
    end
    check({tag, "_done_seen"}, seen, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic check_row(input string tag, input int fr);
    check({tag, "_count"}, got_pix.size(), ROW_W);
    for (int j = 0; j < ROW_W; j++) begin
      if (j < got_pix.size()) begin
        check($sformatf("%s_pix%0d", tag, j), got_pix[j], model(fr, j));
        check($sformatf("%s_last%0d", tag, j), got_last[j], (j == ROW_W - 1));
      end
    end
  endtask

  task automatic clear_q();
    got_pix.delete();
    got_last.delete();
  endtask

  initial begin
    reset_L = 1'b0; start = 1'b0; frac = 2'd0;
    pix_in = 8'd0; pix_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_status", {busy, done, err, pix_ready, out_valid, out_last}, 6'b0);
    check("rst_out_pix", out_pix, 0);
    check("rst_win", filt_win, 0);
    reset_L = 1'b1;
    @(posedge clock);
    #1;

    // Row 1: flat 100, half-pel
    for (int i = 0; i < NPIX; i++) row_pix[i] = 8'd100;
    clear_q();
    d0 = done_cnt;
    start_row(2'd2);
    check("t1_busy", busy, 1);
    feed_row(1'b0, NPIX);
    wait_done("t1");
    check_row("t1", 2);
    check("t1_done_once", done_cnt, d0 + 1);
    check("t1_busy_idle", busy, 0);

    // Row 2 back-to-back: ramp, quarter-pel
    for (int i = 0; i < NPIX; i++) row_pix[i] = 8'(i);
    clear_q();
    start_row(2'd1);
    feed_row(1'b0, NPIX);
    check("t2_first_win", first_win, 64'h0706050403020100);
    wait_done("t2");
    check_row("t2", 1);

    // Row 3: output stalled, credit must stop input after 4 samples
    for (int i = 0; i < NPIX; i++) row_pix[i] = 8'(3 * i + 10);
    clear_q();
    out_ready = 1'b0;
    start_row(2'd3);
    fork
      feed_row(1'b0, NPIX);
      begin
        repeat (40) @(posedge clock);
        @(negedge clock);
        check("t3_pix_ready_low", pix_ready, 0);
        check("t3_fed_at_stall", fed_cnt, 11);
        check("t3_out_valid", out_valid, 1);
        check("t3_nothing_out", got_pix.size(), 0);
        check("t3_head", out_pix, model(3, 0));
        @(negedge clock);
        check("t3_head_hold", out_pix, model(3, 0));
        check("t3_win_hold", filt_win, {row_pix[10], row_pix[9], row_pix[8], row_pix[7],
                                        row_pix[6], row_pix[5], row_pix[4], row_pix[3]});
        @(posedge clock);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_done("t3");
    check_row("t3", 3);

    // Row 4: reset after 10 pixels, then a clean row
    for (int i = 0; i < NPIX; i++) row_pix[i] = 8'(200 + i);
    clear_q();
    start_row(2'd1);
    feed_row(1'b0, 10);
    check("t4_busy_before", busy, 1);
    d0 = done_cnt;
    reset_L = 1'b0;
    #1;
    check("t4_rst_status", {busy, done, err, pix_ready, out_valid, out_last}, 6'b0);
    check("t4_rst_out_pix", out_pix, 0);
    check("t4_rst_win", filt_win, 0);
    repeat (2) @(posedge clock);
    #1;
    reset_L = 1'b1;
    clear_q();
    repeat (5) @(posedge clock);
    #1;
    check("t4_no_done", done_cnt, d0);
    check("t4_no_stale", got_pix.size(), 0);
    for (int i = 0; i < NPIX; i++) row_pix[i] = 8'((i * 11) & 255);
    start_row(2'd3);
    feed_row(1'b0, NPIX);
    wait_done("t4");
    check_row("t4", 3);

    // Row 5: frac=0
    for (int i = 0; i < NPIX; i++) row_pix[i] = 8'(i * 7 + 5);
    clear_q();
`ifdef SUBPEL_FULLPEL_EN
    start_row(2'd0);
    feed_row(1'b0, NPIX);
    wait_done("t5");
    check_row("t5", 0);
`else
    start_row(2'd0);
    check("t5_err_pulse", err, 1);
    check("t5_busy", busy, 0);
    @(posedge clock);
    #1;
    check("t5_err_clear", err, 0);
    check("t5_still_idle", {busy, pix_ready}, 2'b00);
`endif

    // Row 6: gapped input, random output ready, stray starts while running
    for (int i = 0; i < NPIX; i++) row_pix[i] = 8'($urandom_range(0, 255));
    clear_q();
    start_row(2'd2);
    rnd_ready = 1'b1;
    fork
      feed_row(1'b1, NPIX);
      begin
        repeat (6) @(posedge clock);
        #1;
        start = 1'b1;
        frac  = 2'd3;
        @(posedge clock);
        #1;
        frac  = 2'd0;
        @(posedge clock);
        #1;
        start = 1'b0;
        frac  = 2'd2;
        @(negedge clock);
        check("t6_ignored_err", err, 0);
        check("t6_busy", busy, 1);
      end
    join
    wait_done("t6");
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    check_row("t6", 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
